// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG TMS master.
//   tap_state_t : 4-bit TAP controller state, same encoding as the target TAP
//   cmd_op_t    : host command opcode
//   seq_state_t : command sequencer state
//   tap_next()  : IEEE 1149.1 TAP next-state function
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SHIFT_DR = 4'h4,
        TAP_EXIT1_DR = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EXIT2_DR = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SHIFT_IR = 4'hB,
        TAP_EXIT1_IR = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EXIT2_IR = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        OP_RESET    = 2'b00,
        OP_IDLE     = 2'b01,
        OP_SHIFT_IR = 2'b10,
        OP_SHIFT_DR = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NAV,
        S_SHIFT,
        S_POST,
        S_RESP,
        S_RUN
    } seq_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
            default:      n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tms_master_tap_shadow.sv
// jtag_tap_shadow: mirror of the target TAP controller state.
// Advances on every clk edge using the TMS bit currently presented to the TAP.
//   clk       in   TCK
//   TRST      in   asynchronous active-high reset, forces Test_Logic_Reset
//   tms       in   registered TMS being driven to the TAP
//   tap_state out  shadow TAP state
module jtag_tap_shadow
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       TRST,
    input  logic       tms,
    output tap_state_t tap_state
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        state_d = tap_next(state_q, tms);
    end

    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign tap_state = state_q;

endmodule

// File: rtl/jtag_tms_master.sv
// jtag_tms_master: JTAG initiator. Turns RESET / IDLE / SHIFT_IR / SHIFT_DR
// commands into registered TMS/TDI streams, captures TDO into a response word
// and tracks the target TAP state through a shadow copy.
// Optional feature macro: JTAG_TDO_CHECK_EN (adds expect/mask compare).
//   clk, TRST            TCK and asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op, cmd_len, cmd_data payload
//   rsp_valid/rsp_ready  response handshake; rsp_data (TDO, LSB first), rsp_err
//   tms, tdi, tdo        TAP pins (tms/tdi registered)
//   tap_state            shadow TAP state
//   cmd_expect, cmd_mask, rsp_mismatch   only with JTAG_TDO_CHECK_EN
module jtag_tms_master
    import jtag_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               TRST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_TDO_CHECK_EN
    input  logic [MAX_LEN-1:0] cmd_expect,
    input  logic [MAX_LEN-1:0] cmd_mask,
    output logic               rsp_mismatch,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    seq_state_t         seq_q,       seq_d;
    cmd_op_t            op_q,        op_d;
    logic [LEN_W-1:0]   len_q,       len_d;
    logic [MAX_LEN-1:0] data_q,      data_d;
    logic [3:0]         nav_q,       nav_d;
    logic [2:0]         nav_cnt_q,   nav_cnt_d;
    logic [LEN_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [LEN_W-1:0]   run_cnt_q,   run_cnt_d;
    logic               post_q,      post_d;
    logic               tms_q,       tms_d;
    logic               tdi_q,       tdi_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q,   rsp_err_d;
    logic [MAX_LEN-1:0] rsp_data_q,  rsp_data_d;
`ifdef JTAG_TDO_CHECK_EN
    logic [MAX_LEN-1:0] exp_q,       exp_d;
    logic [MAX_LEN-1:0] mask_q,      mask_d;
    logic               mism_q,      mism_d;
    logic [MAX_LEN-1:0] len_mask;
`endif

    tap_state_t tap_q;
    logic       at_tlr;
    logic [4:0] nav_pat;
    logic [2:0] nav_len;

    jtag_tap_shadow u_shadow (
        .clk       (clk),
        .TRST      (TRST),
        .tms       (tms_q),
        .tap_state (tap_q)
    );

    assign cmd_ready = (seq_q == S_IDLE) && !rsp_valid_q;
    assign at_tlr    = (tap_q == TAP_TLR);

    always_comb begin
        seq_d       = seq_q;
        op_d        = op_q;
        len_d       = len_q;
        data_d      = data_q;
        nav_d       = nav_q;
        nav_cnt_d   = nav_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        run_cnt_d   = run_cnt_q;
        post_d      = post_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
`ifdef JTAG_TDO_CHECK_EN
        exp_d       = exp_q;
        mask_d      = mask_q;
        mism_d      = mism_q;
        len_mask    = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
`endif

        // Navigation pattern, LSB first; a leading 0 leaves TLR for RTI.
        if (cmd_op_t'(cmd_op) == OP_RESET) begin
            nav_pat = 5'b11111;
            nav_len = 3'd5;
        end else begin
            nav_pat = (cmd_op_t'(cmd_op) == OP_SHIFT_IR) ? 5'b00011 : 5'b00001;
            nav_len = (cmd_op_t'(cmd_op) == OP_SHIFT_IR) ? 3'd4 : 3'd3;
            if (at_tlr) begin
                nav_pat = {nav_pat[3:0], 1'b0};
                nav_len = nav_len + 3'd1;
            end
        end

        case (seq_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op_t'(cmd_op);
                    len_d      = cmd_len;
                    data_d     = cmd_data;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    post_d     = 1'b0;
                    bit_cnt_d  = '0;
`ifdef JTAG_TDO_CHECK_EN
                    exp_d      = cmd_expect;
                    mask_d     = cmd_mask;
                    mism_d     = 1'b0;
`endif
                    case (cmd_op_t'(cmd_op))
                        OP_IDLE: begin
                            if (!at_tlr && cmd_len == '0) begin
                                seq_d       = S_RESP;
                                rsp_valid_d = 1'b1;
                            end else begin
                                // run_cnt counts the cycles left after the first one
                                seq_d     = S_RUN;
                                tms_d     = 1'b0;
                                run_cnt_d = at_tlr ? cmd_len : cmd_len - LEN_W'(1);
                            end
                        end
                        OP_RESET: begin
                            seq_d     = S_NAV;
                            tms_d     = nav_pat[0];
                            nav_d     = nav_pat[4:1];
                            nav_cnt_d = nav_len - 3'd1;
                        end
                        default: begin
                            if (cmd_len == '0 || cmd_len > MAX_LEN_L) begin
                                seq_d       = S_RESP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                            end else begin
                                seq_d     = S_NAV;
                                tms_d     = nav_pat[0];
                                nav_d     = nav_pat[4:1];
                                nav_cnt_d = nav_len - 3'd1;
                            end
                        end
                    endcase
                end
            end
            S_NAV: begin
                if (nav_cnt_q != 3'd0) begin
                    tms_d     = nav_q[0];
                    nav_d     = {1'b0, nav_q[3:1]};
                    nav_cnt_d = nav_cnt_q - 3'd1;
                end else if (op_q == OP_RESET) begin
                    seq_d       = S_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    seq_d     = S_SHIFT;
                    tms_d     = (len_q == LEN_W'(1));
                    tdi_d     = data_q[0];
                    data_d    = data_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (tap_q == TAP_SHIFT_DR || tap_q == TAP_SHIFT_IR) begin
                    for (int unsigned i = 0; i < MAX_LEN; i++) begin
                        if (LEN_W'(i) == bit_cnt_q) begin
                            rsp_data_d[i] = tdo;
                        end
                    end
                end
                if (bit_cnt_q + LEN_W'(1) == len_q) begin
                    seq_d  = S_POST;
                    tms_d  = 1'b1;
                    tdi_d  = 1'b0;
                    post_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                    tms_d     = (bit_cnt_q + LEN_W'(2) == len_q);
                    tdi_d     = data_q[0];
                    data_d    = data_q >> 1;
                end
            end
            S_POST: begin
                if (!post_q) begin
                    post_d = 1'b1;
                    tms_d  = 1'b0;
                end else begin
                    seq_d       = S_RESP;
                    rsp_valid_d = 1'b1;
`ifdef JTAG_TDO_CHECK_EN
                    mism_d      = |((rsp_data_q ^ exp_q) & mask_q & len_mask);
`endif
                end
            end
            S_RUN: begin
                if (run_cnt_q != '0) begin
                    run_cnt_d = run_cnt_q - LEN_W'(1);
                end else begin
                    seq_d       = S_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    seq_d       = S_IDLE;
                end
            end
            default: seq_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            seq_q       <= S_IDLE;
            op_q        <= OP_RESET;
            len_q       <= '0;
            data_q      <= '0;
            nav_q       <= '0;
            nav_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            run_cnt_q   <= '0;
            post_q      <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
`ifdef JTAG_TDO_CHECK_EN
            exp_q       <= '0;
            mask_q      <= '0;
            mism_q      <= 1'b0;
`endif
        end else begin
            seq_q       <= seq_d;
            op_q        <= op_d;
            len_q       <= len_d;
            data_q      <= data_d;
            nav_q       <= nav_d;
            nav_cnt_q   <= nav_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            run_cnt_q   <= run_cnt_d;
            post_q      <= post_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
`ifdef JTAG_TDO_CHECK_EN
            exp_q       <= exp_d;
            mask_q      <= mask_d;
            mism_q      <= mism_d;
`endif
        end
    end

    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign tap_state = tap_q;
`ifdef JTAG_TDO_CHECK_EN
    assign rsp_mismatch = mism_q;
`endif

endmodule

// File: tb/tb_jtag_tms_master.sv
// Directed testbench for jtag_tms_master. Per-cycle TMS/TDI/TAP-state logs are
// compared against hand-derived sequences. Compare tests are active only when
// JTAG_TDO_CHECK_EN is defined.
module tb_jtag_tms_master;

    logic        clk = 1'b0;
    logic        TRST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic [3:0]  tap_state;
`ifdef JTAG_TDO_CHECK_EN
    logic [31:0] cmd_expect = '0;
    logic [31:0] cmd_mask = '0;
    logic        rsp_mismatch;
`endif

    logic loop_en = 1'b0;
    logic tie_val = 1'b0;
    assign tdo = loop_en ? tdi : tie_val;

    jtag_tms_master #(.MAX_LEN(32), .LEN_W(6)) dut (
        .clk       (clk),
        .TRST      (TRST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
`ifdef JTAG_TDO_CHECK_EN
        .cmd_expect   (cmd_expect),
        .cmd_mask     (cmd_mask),
        .rsp_mismatch (rsp_mismatch),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tap_state (tap_state)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc;
    logic [63:0] tms_log;
    logic [63:0] tdi_log;
    logic [3:0]  tap_log [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command and logs pins each cycle until rsp_valid (bounded).
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!cmd_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("cmd_ready", cmd_ready, 1);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
        n_cyc   = 0;
        tms_log = '0;
        tdi_log = '0;
        while (!rsp_valid && n_cyc < 200) begin
            if (n_cyc < 64) begin
                tms_log[n_cyc] = tms;
                tdi_log[n_cyc] = tdi;
                tap_log[n_cyc] = tap_state;
            end
            n_cyc++;
            @(negedge clk);
        end
        check("rsp_valid_seen", rsp_valid, 1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic        ready_seen;
        logic        unstable;
        logic [31:0] held;

        repeat (3) @(negedge clk);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_tap", tap_state, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        TRST = 1'b0;

        // RESET command
        run_cmd(2'b00, 6'd0, 32'h0);
        check("reset_cycles", n_cyc, 5);
        check("reset_tms", tms_log[31:0], 32'h1F);
        check("reset_tap", tap_state, 4'h0);
        check("reset_err", rsp_err, 0);
        ack();
        check("reset_tms_hold", tms, 1);

        // SHIFT_DR L=8 from TLR, loopback
        loop_en = 1'b1;
        run_cmd(2'b11, 6'd8, 32'hA5);
        check("dr8_cycles", n_cyc, 14);
        check("dr8_tms", tms_log[31:0], 32'h1802);
        check("dr8_tdi", tdi_log[31:0], 32'hA50);
        check("dr8_rsp", rsp_data, 32'hA5);
        check("dr8_tap", tap_state, 4'h1);
        check("dr8_err", rsp_err, 0);
        ack();

        // SHIFT_IR L=4 from RTI, tdo tied high
        loop_en = 1'b0;
        tie_val = 1'b1;
        run_cmd(2'b10, 6'd4, 32'h3);
        check("ir4_cycles", n_cyc, 10);
        check("ir4_tms", tms_log[31:0], 32'h183);
        check("ir4_tdi", tdi_log[31:0], 32'h30);
        check("ir4_rsp", rsp_data, 32'hF);
        check("ir4_tap_shift", tap_log[4], 4'hB);
        check("ir4_tap_exit1", tap_log[8], 4'hC);
        check("ir4_tap_upd", tap_log[9], 4'hF);
        check("ir4_tap_end", tap_state, 4'h1);
        ack();
        check("ir4_tms_hold", tms, 0);

        // Bad lengths
        run_cmd(2'b11, 6'd0, 32'hFF);
        check("len0_cycles", n_cyc, 0);
        check("len0_err", rsp_err, 1);
        check("len0_data", rsp_data, 0);
        check("len0_tms", tms, 0);
        ack();
        run_cmd(2'b11, 6'd33, 32'hFF);
        check("len33_cycles", n_cyc, 0);
        check("len33_err", rsp_err, 1);
        check("len33_data", rsp_data, 0);
        ack();

        // IDLE 3 and IDLE 0 from RTI
        run_cmd(2'b01, 6'd3, 32'h0);
        check("idle3_cycles", n_cyc, 3);
        check("idle3_tms", tms_log[31:0], 32'h0);
        check("idle3_err", rsp_err, 0);
        check("idle3_tap", tap_state, 4'h1);
        ack();
        run_cmd(2'b01, 6'd0, 32'h0);
        check("idle0_cycles", n_cyc, 0);
        ack();

        // SHIFT_DR L=1 and L=32 from RTI, loopback
        loop_en = 1'b1;
        run_cmd(2'b11, 6'd1, 32'h1);
        check("dr1_cycles", n_cyc, 6);
        check("dr1_tms", tms_log[31:0], 32'h19);
        check("dr1_rsp", rsp_data, 32'h1);
        ack();
        run_cmd(2'b11, 6'd32, 32'hDEADBEEF);
        check("dr32_cycles", n_cyc, 37);
        check("dr32_tms_lo", tms_log[31:0], 32'h1);
        check("dr32_tms_hi", tms_log[63:32], 32'hC);
        check("dr32_rsp", rsp_data, 32'hDEADBEEF);
        ack();

        // Response held for 10 cycles
        loop_en = 1'b0;
        tie_val = 1'b1;
        run_cmd(2'b11, 6'd8, 32'h3C);
        check("hold_rsp", rsp_data, 32'hFF);
        held       = rsp_data;
        ready_seen = 1'b0;
        unstable   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_ready) ready_seen = 1'b1;
            if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_err !== 1'b0) unstable = 1'b1;
        end
        check("hold_ready_low", ready_seen, 0);
        check("hold_stable", unstable, 0);
        ack();

        // TRST during S_SHIFT
        tie_val = 1'b0;
        @(negedge clk);
        check("trst_pre_ready", cmd_ready, 1);
        cmd_op    = 2'b11;
        cmd_len   = 6'd16;
        cmd_data  = 32'h0000FFFF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("trst_in_shift", tap_state, 4'h4);
        check("trst_tdi_shift", tdi, 1);
        TRST = 1'b1;
        #1;
        check("trst_tms", tms, 1);
        check("trst_tdi", tdi, 0);
        check("trst_tap", tap_state, 4'h0);
        check("trst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        TRST = 1'b0;
        repeat (5) @(negedge clk);
        check("trst_no_rsp", rsp_valid, 0);
        check("trst_idle_ready", cmd_ready, 1);
        check("trst_tap_after", tap_state, 4'h0);

        // IDLE 2 from TLR
        run_cmd(2'b01, 6'd2, 32'h0);
        check("idle2_tlr_cycles", n_cyc, 3);
        check("idle2_tlr_tms", tms_log[31:0], 32'h0);
        check("idle2_tlr_tap", tap_state, 4'h1);
        ack();

`ifdef JTAG_TDO_CHECK_EN
        tie_val    = 1'b0;
        cmd_expect = 32'hFF;
        cmd_mask   = 32'h0F;
        run_cmd(2'b11, 6'd8, 32'h0);
        check("cmp_mism_on", rsp_mismatch, 1);
        ack();
        cmd_mask = 32'h0;
        run_cmd(2'b11, 6'd8, 32'h0);
        check("cmp_mask0", rsp_mismatch, 0);
        ack();
        cmd_mask = 32'hF00;
        run_cmd(2'b11, 6'd8, 32'h0);
        check("cmp_lenmask", rsp_mismatch, 0);
        ack();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
